// File: rtl/addsub_accum_pkg.sv
// -----------------------------------------------------------------------------
// addsub_accum_pkg
//   Shared types and helpers for the add/subtract result accumulator.
//   - state_t      : run-control FSM states (IDLE, RUN, DONE)
//   - acc_max/min  : saturation bounds of a signed accumulator of width w
// -----------------------------------------------------------------------------
package addsub_accum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Largest value a w-bit two's-complement register can hold.
    function automatic longint acc_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Smallest value a w-bit two's-complement register can hold.
    function automatic longint acc_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/addsub_accum_if.sv
// -----------------------------------------------------------------------------
// addsub_accum_if
//   Sample stream from the add/subtract stage into the accumulator.
//   Signals (named from the accumulator's point of view):
//     i_valid      upstream sample valid
//     o_ready      accumulator takes the sample this cycle
//     i_mode       0 add, 1 subtract
//     i_ovr        overflow flag (borrow when subtracting)
//     i_arith_out  DATA_WD+1 bit result word
//   Modports: master = upstream stage, slave = accumulator.
// -----------------------------------------------------------------------------
interface addsub_accum_if #(
    parameter int DATA_WD = 4
) ();
    logic               i_valid;
    logic               o_ready;
    logic               i_mode;
    logic               i_ovr;
    logic [DATA_WD:0]   i_arith_out;

    modport master (
        output i_valid, i_mode, i_ovr, i_arith_out,
        input  o_ready
    );

    modport slave (
        input  i_valid, i_mode, i_ovr, i_arith_out,
        output o_ready
    );
endinterface

// File: rtl/addsub_sample_sext.sv
// -----------------------------------------------------------------------------
// addsub_sample_sext
//   Combinational conversion of an add/subtract result word to a signed
//   DATA_WD+2 bit sample.
//   Ports:
//     i_mode       0 add, 1 subtract
//     i_ovr        borrow flag in subtract mode
//     i_arith_out  DATA_WD+1 bit result word
//     o_sample     signed DATA_WD+2 bit value
// -----------------------------------------------------------------------------
module addsub_sample_sext #(
    parameter int DATA_WD = 4
) (
    input  logic                      i_mode,
    input  logic                      i_ovr,
    input  logic [DATA_WD:0]          i_arith_out,
    output logic signed [DATA_WD+1:0] o_sample
);

    always_comb begin
        o_sample = '0;
        if (!i_mode) begin
            // Add: the top bit is the carry, so the word is a plain unsigned sum.
            o_sample = {1'b0, i_arith_out};
        end else if (!i_ovr) begin
            o_sample = {2'b00, i_arith_out[DATA_WD-1:0]};
        end else begin
            // Borrow: value is low - 2^DATA_WD, i.e. prefix the low bits with 2'b11.
            o_sample = {2'b11, i_arith_out[DATA_WD-1:0]};
        end
    end

endmodule

// File: rtl/addsub_accum.sv
// -----------------------------------------------------------------------------
// addsub_accum
//   Accumulates a programmed number of add/subtract results into a saturating
//   signed accumulator and counts borrow samples.
//   Ports:
//     i_clk, i_rst   clock, synchronous active-high reset
//     i_start        start a run (sampled in IDLE only)
//     i_len          samples per run, captured with i_start
//     bus            sample stream (slave side of addsub_accum_if)
//     o_acc          signed accumulated sum, held after the run
//     o_ovr_cnt      saturating count of borrow samples this run
//     o_sat          sticky: accumulator clipped this run
//     o_busy         high while in RUN
//     o_done         one-cycle pulse at end of run
//   Optional (ADDSUB_ACCUM_MINMAX_EN):
//     o_min, o_max   min/max converted sample of the current run
// -----------------------------------------------------------------------------
module addsub_accum
    import addsub_accum_pkg::*;
#(
    parameter int DATA_WD = 4,
    parameter int ACC_WD  = 12,
    parameter int CNT_WD  = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [CNT_WD-1:0]         i_len,
    addsub_accum_if.slave             bus,
    output logic signed [ACC_WD-1:0]  o_acc,
    output logic [CNT_WD-1:0]         o_ovr_cnt,
    output logic                      o_sat,
    output logic                      o_busy,
    output logic                      o_done
`ifdef ADDSUB_ACCUM_MINMAX_EN
    ,
    output logic signed [DATA_WD+1:0] o_min,
    output logic signed [DATA_WD+1:0] o_max
`endif
);

    localparam int SMP_W = DATA_WD + 2;
    localparam int SUM_W = ACC_WD + 1;

    localparam logic signed [SUM_W-1:0]  SUM_MAX = SUM_W'(acc_max(ACC_WD));
    localparam logic signed [SUM_W-1:0]  SUM_MIN = SUM_W'(acc_min(ACC_WD));
    localparam logic signed [ACC_WD-1:0] ACC_MAX = ACC_WD'(acc_max(ACC_WD));
    localparam logic signed [ACC_WD-1:0] ACC_MIN = ACC_WD'(acc_min(ACC_WD));

    state_t                   state_q, state_d;
    logic [CNT_WD-1:0]        rem_q;
    logic                     accept;
    logic                     start_go;
    logic signed [SMP_W-1:0]  sample;
    logic signed [SUM_W-1:0]  sum;

    addsub_sample_sext #(.DATA_WD(DATA_WD)) u_sext (
        .i_mode      (bus.i_mode),
        .i_ovr       (bus.i_ovr),
        .i_arith_out (bus.i_arith_out),
        .o_sample    (sample)
    );

    assign bus.o_ready = (state_q == RUN);
    assign accept      = bus.i_valid && bus.o_ready;
    assign start_go    = (state_q == IDLE) && i_start;

    // One guard bit is enough: |sample| is far below the accumulator range.
    assign sum = $signed({o_acc[ACC_WD-1], o_acc})
               + $signed({{(SUM_W-SMP_W){sample[SMP_W-1]}}, sample});

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start) state_d = (i_len != '0) ? RUN : DONE;
            end
            RUN: begin
                o_busy = 1'b1;
                if (accept && rem_q == CNT_WD'(1)) state_d = DONE;
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rem_q     <= '0;
            o_acc     <= '0;
            o_ovr_cnt <= '0;
            o_sat     <= 1'b0;
        end else if (start_go) begin
            rem_q     <= i_len;
            o_acc     <= '0;
            o_ovr_cnt <= '0;
            o_sat     <= 1'b0;
        end else if (accept) begin
            rem_q <= rem_q - CNT_WD'(1);
            if (sum > SUM_MAX) begin
                o_acc <= ACC_MAX;
                o_sat <= 1'b1;
            end else if (sum < SUM_MIN) begin
                o_acc <= ACC_MIN;
                o_sat <= 1'b1;
            end else begin
                o_acc <= sum[ACC_WD-1:0];
            end
            if (bus.i_mode && bus.i_ovr && !(&o_ovr_cnt))
                o_ovr_cnt <= o_ovr_cnt + CNT_WD'(1);
        end
    end

`ifdef ADDSUB_ACCUM_MINMAX_EN
    localparam logic signed [SMP_W-1:0] SMP_MAX = {1'b0, {(SMP_W-1){1'b1}}};
    localparam logic signed [SMP_W-1:0] SMP_MIN = {1'b1, {(SMP_W-1){1'b0}}};

    // Sentinels are inverted so the first accepted sample replaces both.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_min <= '0;
            o_max <= '0;
        end else if (start_go) begin
            o_min <= SMP_MAX;
            o_max <= SMP_MIN;
        end else if (accept) begin
            if (sample < o_min) o_min <= sample;
            if (sample > o_max) o_max <= sample;
        end
    end
`endif

endmodule
